// File: rtl/ipi_ring_stop.sv
// ipi_ring_stop: ring-side endpoint for inter-processor interrupts, one per core.
//
// Buffers IPI packets from the local system management core and inserts them
// into free ring slots. It also strips IPIs addressed to this core out of the
// passing ring traffic and hands them to the core over a valid/accept
// handshake. All other traffic is forwarded with one register stage.
//
// Optional feature macro: IPI_RX_FIFO_EN
//   defined   -> delivery storage is an RX_DEPTH-entry FIFO
//   undefined -> delivery storage is a single register (full while rx_issue=1)
//
// Ports:
//   clk             rising-edge clock
//   reset_n         asynchronous active-low reset
//   core_id         this stop's index, static after reset
//   ring_in_packet  slot arriving from the upstream stop
//   ring_out_packet registered slot to the downstream stop
//   inj_issue       local core presents inj_packet for injection
//   inj_packet      packet to inject
//   inj_ready       injection FIFO not full (registered state only)
//   rx_issue        rx_packet valid
//   rx_packet       packet delivered to the local core
//   rx_issuing      local core accepts rx_packet this cycle
//   inj_drop_count  saturating count of injections lost to a full FIFO

package ipi_ring_pkg;
  localparam int MAX_CORES = 16;

  typedef logic [3:0] core_id_t;

  typedef enum logic [1:0] {
    RING_PACKET_KIND_NONE = 2'd0,
    RING_PACKET_KIND_IPI  = 2'd1,
    RING_PACKET_KIND_DATA = 2'd2,
    RING_PACKET_KIND_CTRL = 2'd3
  } ring_packet_kind_t;

  typedef struct packed {
    logic                  valid;
    ring_packet_kind_t     kind;
    core_id_t              src;
    logic [MAX_CORES-1:0]  dest_vector;
    logic [15:0]           ipi_reason;
  } ring_packet;
endpackage

module ipi_ring_stop
  import ipi_ring_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int INJ_DEPTH = 4,
  parameter int RX_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  core_id_t    core_id,
  input  ring_packet  ring_in_packet,
  output ring_packet  ring_out_packet,
  input  logic        inj_issue,
  input  ring_packet  inj_packet,
  output logic        inj_ready,
  output logic        rx_issue,
  output ring_packet  rx_packet,
  input  logic        rx_issuing,
  output logic [15:0] inj_drop_count
);

  function automatic logic [MAX_CORES-1:0] make_dest_mask(input int n);
    logic [MAX_CORES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_CORES; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [MAX_CORES-1:0] DEST_MASK = make_dest_mask(NUM_CORES);
  localparam int INJ_AW = (INJ_DEPTH > 1) ? $clog2(INJ_DEPTH) : 1;
  localparam int INJ_CW = $clog2(INJ_DEPTH + 1);

  // ---------------------------------------------------------------------------
  // Ring-side decode (combinational, feeds the single output register)
  // ---------------------------------------------------------------------------
  logic                 rx_full;
  logic                 rx_take;
  logic                 rx_pop;
  logic [MAX_CORES-1:0] in_dest_m;
  logic                 addressed;
  ring_packet           fwd;
  ring_packet           ring_out_d;
  ring_packet           ring_out_p1;

  logic                 head_vld;
  ring_packet           head_q;
  logic                 inj_pop;

  assign in_dest_m = ring_in_packet.dest_vector & DEST_MASK;
  assign addressed = ring_in_packet.valid &&
                     (ring_in_packet.kind == RING_PACKET_KIND_IPI) &&
                     in_dest_m[core_id];
  // A full delivery store (registered view) makes the slot recirculate.
  assign rx_take   = addressed && !rx_full;

  always_comb begin
    fwd = ring_in_packet;
    if (rx_take) begin
      fwd.dest_vector[core_id] = 1'b0;
    end
    // Empty slots leave the stop zeroed so stale payload never travels on.
    if (!fwd.valid || (rx_take && ((fwd.dest_vector & DEST_MASK) == '0))) begin
      fwd = '0;
    end
    inj_pop    = 1'b0;
    ring_out_d = fwd;
    // Passing traffic wins; only a free slot takes the injection head.
    if (!fwd.valid && head_vld) begin
      ring_out_d = head_q;
      inj_pop    = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1: ring output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ring_out_p1 <= '0;
    end else begin
      ring_out_p1 <= ring_out_d;
    end
  end

  assign ring_out_packet = ring_out_p1;

  // ---------------------------------------------------------------------------
  // Injection FIFO: storage array plus a prefetched head register. inj_count
  // covers both, so capacity is INJ_DEPTH in total. The head is loaded one
  // edge after the push, which gives the two-edge minimum injection latency.
  // ---------------------------------------------------------------------------
  ring_packet           inj_mem [INJ_DEPTH];
  logic [INJ_AW-1:0]    inj_wr_ptr;
  logic [INJ_AW-1:0]    inj_rd_ptr;
  logic [INJ_CW-1:0]    inj_count;
  logic [INJ_CW-1:0]    inj_mem_cnt;
  logic                 inj_nonzero;
  logic                 inj_push;
  logic                 inj_drop;
  logic                 head_load;
  ring_packet           inj_masked;

  assign inj_ready   = (inj_count != INJ_CW'(INJ_DEPTH));
  assign inj_nonzero = |(inj_packet.dest_vector & DEST_MASK);
  // Packets with no reachable destination vanish without touching any count.
  assign inj_push    = inj_issue && inj_ready && inj_nonzero;
  assign inj_drop    = inj_issue && !inj_ready && inj_nonzero;
  assign inj_mem_cnt = inj_count - INJ_CW'(head_vld);
  assign head_load   = (inj_mem_cnt != '0) && (!head_vld || inj_pop);

  always_comb begin
    inj_masked             = inj_packet;
    inj_masked.valid       = 1'b1;
    inj_masked.dest_vector = inj_packet.dest_vector & DEST_MASK;
  end

  always_ff @(posedge clk) begin
    if (inj_push) begin
      inj_mem[inj_wr_ptr] <= inj_masked;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inj_wr_ptr     <= '0;
      inj_rd_ptr     <= '0;
      inj_count      <= '0;
      head_vld       <= 1'b0;
      head_q         <= '0;
      inj_drop_count <= '0;
    end else begin
      if (inj_push) begin
        inj_wr_ptr <= inj_wr_ptr + INJ_AW'(1);
      end
      if (head_load) begin
        head_q     <= inj_mem[inj_rd_ptr];
        head_vld   <= 1'b1;
        inj_rd_ptr <= inj_rd_ptr + INJ_AW'(1);
      end else if (inj_pop) begin
        head_vld   <= 1'b0;
      end
      case ({inj_push, inj_pop})
        2'b10:   inj_count <= inj_count + INJ_CW'(1);
        2'b01:   inj_count <= inj_count - INJ_CW'(1);
        default: inj_count <= inj_count;
      endcase
      if (inj_drop && (inj_drop_count != 16'hFFFF)) begin
        inj_drop_count <= inj_drop_count + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Delivery storage
  // ---------------------------------------------------------------------------
`ifdef IPI_RX_FIFO_EN
  localparam int RX_AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam int RX_CW = $clog2(RX_DEPTH + 1);

  ring_packet        rx_mem [RX_DEPTH];
  logic [RX_AW-1:0]  rx_wr_ptr;
  logic [RX_AW-1:0]  rx_rd_ptr;
  logic [RX_CW-1:0]  rx_count;

  assign rx_full   = (rx_count == RX_CW'(RX_DEPTH));
  assign rx_issue  = (rx_count != '0);
  assign rx_pop    = rx_issue && rx_issuing;
  assign rx_packet = rx_issue ? rx_mem[rx_rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rx_take) begin
      rx_mem[rx_wr_ptr] <= ring_in_packet;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_take) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
      case ({rx_take, rx_pop})
        2'b10:   rx_count <= rx_count + RX_CW'(1);
        2'b01:   rx_count <= rx_count - RX_CW'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end
`else
  ring_packet rx_q;
  logic       rx_vld;

  assign rx_full   = rx_vld;
  assign rx_issue  = rx_vld;
  assign rx_pop    = rx_vld && rx_issuing;
  assign rx_packet = rx_vld ? rx_q : '0;

  // rx_take already implies the register is empty, so take and pop never meet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_q   <= '0;
      rx_vld <= 1'b0;
    end else if (rx_take) begin
      rx_q   <= ring_in_packet;
      rx_vld <= 1'b1;
    end else if (rx_pop) begin
      rx_vld <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_ipi_ring_stop.sv
// Directed self-checking bench for ipi_ring_stop (NUM_CORES=4, core_id=1).
// Expected ring outputs and delivered packets are queued as stimulus is
// driven and popped when the DUT is sampled, one time unit after each edge.
module tb_ipi_ring_stop;
  import ipi_ring_pkg::*;

`ifdef IPI_RX_FIFO_EN
  localparam int RX_CAP = 4;
`else
  localparam int RX_CAP = 1;
`endif

  typedef struct {
    ring_packet pkt;
    bit         whole;   // 1: compare full packet, 0: compare valid bit only
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  core_id_t    core_id;
  ring_packet  ring_in_packet;
  ring_packet  ring_out_packet;
  logic        inj_issue;
  ring_packet  inj_packet;
  logic        inj_ready;
  logic        rx_issue;
  ring_packet  rx_packet;
  logic        rx_issuing;
  logic [15:0] inj_drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t       exp_out_q[$];
  ring_packet exp_rx_q[$];
  ring_packet inj_exp[$];

  ipi_ring_stop #(.NUM_CORES(4), .INJ_DEPTH(4), .RX_DEPTH(4)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .core_id         (core_id),
    .ring_in_packet  (ring_in_packet),
    .ring_out_packet (ring_out_packet),
    .inj_issue       (inj_issue),
    .inj_packet      (inj_packet),
    .inj_ready       (inj_ready),
    .rx_issue        (rx_issue),
    .rx_packet       (rx_packet),
    .rx_issuing      (rx_issuing),
    .inj_drop_count  (inj_drop_count)
  );

  always #5 clk = ~clk;

  function automatic ring_packet mk(input logic v, input ring_packet_kind_t k,
                                    input logic [15:0] dest, input logic [15:0] reason);
    ring_packet p;
    p.valid       = v;
    p.kind        = k;
    p.src         = 4'd2;
    p.dest_vector = dest;
    p.ipi_reason  = reason;
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag);
    exp_t e;
    if (exp_out_q.size() == 0) begin
      chk({tag, "_outq_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_out_q.pop_front();
      if (e.whole) chk(tag, 64'(ring_out_packet), 64'(e.pkt));
      else         chk(tag, 64'(ring_out_packet.valid), 64'(e.pkt.valid));
    end
  endtask

  task automatic chk_rx(input string tag);
    ring_packet p;
    chk({tag, "_issue"}, 64'(rx_issue), 64'd1);
    if (exp_rx_q.size() == 0) begin
      chk({tag, "_rxq_empty"}, 64'd1, 64'd0);
    end else begin
      p = exp_rx_q.pop_front();
      chk({tag, "_pkt"}, 64'(rx_packet), 64'(p));
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ring_out"}, 64'(ring_out_packet), 64'd0);
    chk({tag, "_inj_ready"}, 64'(inj_ready), 64'd1);
    chk({tag, "_rx_issue"}, 64'(rx_issue), 64'd0);
    chk({tag, "_rx_packet"}, 64'(rx_packet), 64'd0);
    chk({tag, "_drop"}, 64'(inj_drop_count), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ring_packet p;
    ring_packet q;
    core_id        = 4'd1;
    ring_in_packet = '0;
    inj_issue      = 1'b0;
    inj_packet     = '0;
    rx_issuing     = 1'b0;

    // Reset values while reset is held, then idle after release.
    #2;
    chk_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    step();
    chk_reset_outputs("idle");

    // Single-destination IPI for this core: delivered, slot emptied.
    p = mk(1'b1, RING_PACKET_KIND_IPI, 16'h0002, 16'hCAFE);
    ring_in_packet = p;
    exp_rx_q.push_back(p);
    exp_out_q.push_back('{pkt: '0, whole: 1'b0});
    step();
    ring_in_packet = '0;
    chk_out("A_out_valid");
    chk("A_reason", 64'(rx_packet.ipi_reason), 64'hCAFE);
    chk_rx("A_rx");
    rx_issuing = 1'b1;
    step();
    rx_issuing = 1'b0;
    chk("A_popped", 64'(rx_issue), 64'd0);

    // Multicast: delivered locally, forwarded with own bit cleared.
    p = mk(1'b1, RING_PACKET_KIND_IPI, 16'h0006, 16'h1234);
    ring_in_packet = p;
    exp_rx_q.push_back(p);
    exp_out_q.push_back('{pkt: mk(1'b1, RING_PACKET_KIND_IPI, 16'h0004, 16'h1234), whole: 1'b1});
    step();
    ring_in_packet = '0;
    chk_out("B_out");
    chk_rx("B_rx");
    rx_issuing = 1'b1;
    step();
    rx_issuing = 1'b0;

    // Delivery storage fills; the excess slot passes unchanged.
    for (int i = 0; i <= RX_CAP; i++) begin
      p = mk(1'b1, RING_PACKET_KIND_IPI, 16'h0002, 16'h0100 + 16'(i));
      ring_in_packet = p;
      if (i < RX_CAP) begin
        exp_rx_q.push_back(p);
        exp_out_q.push_back('{pkt: '0, whole: 1'b0});
      end else begin
        exp_out_q.push_back('{pkt: p, whole: 1'b1});
      end
      step();
      chk_out($sformatf("C_out%0d", i));
    end
    ring_in_packet = '0;
    chk_rx("C_rx_first");
    rx_issuing = 1'b1;
    step();
    rx_issuing = 1'b0;
    // The recirculated slot comes back and is now accepted.
    p = mk(1'b1, RING_PACKET_KIND_IPI, 16'h0002, 16'h0100 + 16'(RX_CAP));
    ring_in_packet = p;
    exp_rx_q.push_back(p);
    exp_out_q.push_back('{pkt: '0, whole: 1'b0});
    step();
    ring_in_packet = '0;
    chk_out("C_retry_out");
    for (int g = 0; g < 16 && exp_rx_q.size() > 0; g++) begin
      chk_rx($sformatf("C_drain%0d", g));
      rx_issuing = 1'b1;
      step();
      rx_issuing = 1'b0;
    end
    chk("C_empty", 64'(rx_issue), 64'd0);

    // Five injection requests against a busy ring: four pushes, one drop.
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("D_ready%0d", i), 64'(inj_ready), (i < 4) ? 64'd1 : 64'd0);
      inj_issue  = 1'b1;
      inj_packet = mk(1'b0, RING_PACKET_KIND_IPI, 16'hF008, 16'h0200 + 16'(i));
      if (i < 4) inj_exp.push_back(mk(1'b1, RING_PACKET_KIND_IPI, 16'h0008, 16'h0200 + 16'(i)));
      p = mk(1'b1, RING_PACKET_KIND_DATA, 16'h0000, 16'h0300 + 16'(i));
      ring_in_packet = p;
      exp_out_q.push_back('{pkt: p, whole: 1'b1});
      step();
      chk_out($sformatf("D_busy%0d", i));
    end
    inj_issue      = 1'b0;
    ring_in_packet = '0;
    chk("D_full", 64'(inj_ready), 64'd0);
    chk("D_drop", 64'(inj_drop_count), 64'd1);
    // Free slots now arrive: queued packets leave in order, valid forced, dest masked.
    for (int i = 0; i < 4; i++) begin
      exp_out_q.push_back('{pkt: inj_exp.pop_front(), whole: 1'b1});
      step();
      chk_out($sformatf("D_inj%0d", i));
      if (i == 0) chk("D_ready_after_pop", 64'(inj_ready), 64'd1);
    end
    step();
    chk("D_drained", 64'(ring_out_packet), 64'd0);

    // Push with no reachable destination: neither push nor drop.
    inj_issue  = 1'b1;
    inj_packet = mk(1'b1, RING_PACKET_KIND_IPI, 16'h0010, 16'hDEAD);
    step();
    inj_issue = 1'b0;
    chk("Z_drop", 64'(inj_drop_count), 64'd1);
    step();
    step();
    chk("Z_ring", 64'(ring_out_packet), 64'd0);

    // Minimum injection latency on an idle ring.
    q = mk(1'b1, RING_PACKET_KIND_IPI, 16'h0008, 16'h4E4E);
    inj_issue  = 1'b1;
    inj_packet = q;
    step();
    inj_issue = 1'b0;
    chk("E_t0", 64'(ring_out_packet), 64'd0);
    step();
    chk("E_t1", 64'(ring_out_packet), 64'd0);
    step();
    chk("E_t2", 64'(ring_out_packet), 64'(q));

    // Asynchronous reset with traffic in flight.
    inj_issue      = 1'b1;
    inj_packet     = mk(1'b1, RING_PACKET_KIND_IPI, 16'h0004, 16'h5A5A);
    ring_in_packet = mk(1'b1, RING_PACKET_KIND_IPI, 16'h0006, 16'hBEEF);
    step();
    inj_issue      = 1'b0;
    ring_in_packet = '0;
    chk("R_pre_valid", 64'(ring_out_packet.valid), 64'd1);
    chk("R_pre_rx", 64'(rx_issue), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk_reset_outputs("R_async");
    exp_out_q.delete();
    exp_rx_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) step();
    chk("R_lost_inj", 64'(ring_out_packet), 64'd0);
    chk("R_lost_rx", 64'(rx_issue), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
